booth_seq_ctrl: RTL and testbench

//   Sequential radix-2 Booth multiplier controller. It owns the A/Q/M working registers
//   and the iteration counter, and issues one add/sub + arithmetic-shift step per clock.

---
 rtl/booth_pkg.sv | 29 ++
 rtl/booth_seq_ctrl_if.sv | 28 ++
 rtl/booth_step.sv | 34 +++
 rtl/booth_seq_ctrl.sv | 91 +++++++++
 tb/tb_booth_seq_ctrl.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier.
//   state_t    : controller state encoding (IDLE/RUN/DONE; 2'd3 is unused and recovers to IDLE)
//   booth_op_t : per-step operation chosen from the low two bits of {Q, q_-1}
//   booth_op() : maps Q[1:0] to the step operation
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    // Booth recoding of the bit pair {Q[0], q_-1}:
    // 01 ends a run of ones (add M), 10 starts one (subtract M).
    function automatic booth_op_t booth_op(input logic [1:0] qpair);
        case (qpair)
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_seq_ctrl_if.sv
// Requester/consumer bus of the sequential Booth multiplier.
//   start        : request, sampled only while the controller is idle
//   multiplicand : signed M, captured with start
//   multiplier   : signed Q, captured with start
//   busy         : controller is not idle
//   done         : one-cycle completion pulse
//   product      : signed 2W-bit result, held until the next completion
// master = requester side, slave = multiplier side.
interface booth_seq_ctrl_if #(
    parameter int W = 5
);
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    modport master (
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration.
//   a, q, m   : current accumulator A[W:0], {multiplier, q_-1} Q[W:0], sign-extended M[W:0]
//   a_nxt     : A after add/sub and arithmetic right shift
//   q_nxt     : Q after the shift (receives the bit shifted out of A)
// Arithmetic is modulo 2^(W+1); the extra A bit keeps -2^(W-1) negatable.
module booth_step
    import booth_pkg::*;
#(
    parameter int W = 5
) (
    input  logic [W:0] a,
    input  logic [W:0] q,
    input  logic [W:0] m,
    output logic [W:0] a_nxt,
    output logic [W:0] q_nxt
);

    logic [W:0] sum;

    always_comb begin
        // NOTE: default assignment first so no path leaves sum unassigned (no latch).
        sum = a;
        case (booth_op(q[1:0]))
            OP_ADD:  sum = a + m;
            OP_SUB:  sum = a - m;
            default: sum = a;
        endcase
    end

    // Arithmetic right shift of {sum, q}: sign bit of A replicated.
    assign a_nxt = {sum[W], sum[W:1]};
    assign q_nxt = {sum[0], q[W:1]};

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential radix-2 Booth multiplier controller.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (aborts any operation, clears product)
//   bus   : booth_seq_ctrl_if.slave (start/operands in, busy/done/product out)
// Holds the A/Q/M working registers, the iteration counter and the FSM; the
// datapath step itself lives in booth_step. One Booth step per clock, W steps
// per product, done pulses in the cycle after the last step.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    booth_seq_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(W + 1);

    state_t           state;
    logic [W:0]       a_reg;
    logic [W:0]       q_reg;
    logic [W:0]       m_reg;
    logic [CNT_W-1:0] count;
    logic [W:0]       a_nxt;
    logic [W:0]       q_nxt;
    logic             busy_q;
    logic             done_q;
    logic [2*W-1:0]   product_q;

    booth_step #(.W(W)) u_step (
        .a     (a_reg),
        .q     (q_reg),
        .m     (m_reg),
        .a_nxt (a_nxt),
        .q_nxt (q_nxt)
    );

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            q_reg     <= '0;
            m_reg     <= '0;
            count     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg  <= '0;
                        m_reg  <= {bus.multiplicand[W-1], bus.multiplicand};
                        q_reg  <= {bus.multiplier, 1'b0};
                        count  <= CNT_W'(W);
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    a_reg <= a_nxt;
                    q_reg <= q_nxt;
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        // Final step: drop A's guard bit and q_-1.
                        product_q <= {a_nxt[W-1:0], q_nxt[W:1]};
                        done_q    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed and exhaustive checks of booth_seq_ctrl at W=5.
module tb_booth_seq_ctrl;

    localparam int W = 5;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    booth_seq_ctrl_if #(.W(W)) bus ();

    booth_seq_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // done must follow a busy cycle and never last two cycles.
    logic prev_busy;
    logic prev_done;
    initial begin
        prev_busy = 1'b0;
        prev_done = 1'b0;
    end
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.done === 1'b1) begin
            check("done_after_busy", {31'd0, prev_busy}, 32'd1);
            check("done_single", {31'd0, prev_done}, 32'd0);
        end
        prev_busy = bus.busy;
        prev_done = bus.done;
    end

    // Advance one edge, sample #1 later; at most 'limit' edges until done.
    task automatic wait_done(input int limit, output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Called #1 after an edge with the controller idle; returns idle.
    task automatic do_op(input int a, input int b, input logic [9:0] exp, input string tag);
        int n;
        logic [9:0] prod0;
        bus.start        = 1'b1;
        bus.multiplicand = 5'(a);
        bus.multiplier   = 5'(b);
        @(posedge clk); #1;
        bus.start        = 1'b0;
        bus.multiplicand = 5'($urandom);
        bus.multiplier   = 5'($urandom);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        prod0 = bus.product;
        n = 0;
        while (bus.done !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
            if (bus.done !== 1'b1)
                check({tag, "_hold"}, {22'd0, bus.product}, {22'd0, prod0});
        end
        check({tag, "_lat"}, n, W);
        check(tag, {22'd0, bus.product}, {22'd0, exp});
        @(posedge clk); #1;
        check({tag, "_done_lo"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int n;
        int t0;
        int t1;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_product", {22'd0, bus.product}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_no_start", {31'd0, bus.busy}, 32'd0);

        // Directed products
        do_op(5, -3, 10'h3F1, "m5_qn3");
        do_op(-16, -16, 10'h100, "mn16_qn16");
        do_op(-16, 15, 10'h310, "mn16_q15");
        do_op(7, 7, 10'h031, "m7_q7");
        do_op(0, -9, 10'h000, "m0_qn9");
        do_op(-9, 0, 10'h000, "mn9_q0");

        // start held high: 5x3, -2x4, 1x-1, one result every W+2 cycles
        bus.start = 1'b1;
        bus.multiplicand = 5'(5);
        bus.multiplier   = 5'(3);
        @(posedge clk); #1;
        bus.multiplicand = 5'(-2);
        bus.multiplier   = 5'(4);
        wait_done(30, n);
        check("held1_lat", n, W);
        check("held1_prod", {22'd0, bus.product}, 32'h00F);
        t0 = cyc;
        @(posedge clk); #1;
        check("held1_gap_idle", {31'd0, bus.busy}, 32'd0);
        @(posedge clk); #1;
        bus.multiplicand = 5'(1);
        bus.multiplier   = 5'(-1);
        check("held2_busy", {31'd0, bus.busy}, 32'd1);
        wait_done(30, n);
        t1 = cyc;
        check("held2_prod", {22'd0, bus.product}, 32'h3F8);
        check("held2_period", t1 - t0, W + 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.start        = 1'b0;
        bus.multiplicand = 5'(13);
        bus.multiplier   = 5'(-11);
        wait_done(30, n);
        check("held3_prod", {22'd0, bus.product}, 32'h3FF);
        check("held3_period", cyc - t1, W + 2);
        @(posedge clk); #1;
        check("held3_idle", {31'd0, bus.busy}, 32'd0);

        // Reset with two steps left: abort, no done, product cleared
        bus.start        = 1'b1;
        bus.multiplicand = 5'(6);
        bus.multiplier   = 5'(7);
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_product", {22'd0, bus.product}, 32'd0);
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            check("abort_no_done", {31'd0, bus.done}, 32'd0);
        end
        check("abort_idle", {31'd0, bus.busy}, 32'd0);
        do_op(6, 7, 10'h02A, "post_abort");

        // Exhaustive sweep against the signed reference product
        for (int a = -16; a < 16; a++) begin
            for (int b = -16; b < 16; b++) begin
                do_op(a, b, 10'(a * b), "sweep");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
